agu_seq: RTL and testbench
==========================

Name: agu_seq

Overview:
- Self-sequencing address generator for the in-place constant-geometry radix-2 FFT datapath.
- Walks every (stage, pair) butterfly for a run-time-selected transform size up to N.
- Emits sample addresses as ROT_L(2*pair, stage) and ROT_L(2*pair+1, stage), plus a size-scaled twiddle address, through a valid/ready handshake.
- Supersedes the free-running combinational-plus-register AGU: adds internal counters, start/done control, back-pressure, run-time size and programmable inter-stage drain gaps.

Parameters:
- N, 1024: maximum transform size; power of two, >= 4. LOG2N = $clog2(N).
- STAGE_GAP, 0: idle cycles inserted between stages for datapath drain/hazard avoidance; range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a transform; honoured only in IDLE.
- cfg_log2n  input  $clog2(LOG2N+1)  transform size L = log2(points); sampled with start.
- busy  output  1  high while a transform is in progress.
- done  output  1  one-cycle pulse; the last beat was accepted.
- out_valid  output  1  address beat valid.
- out_ready  input  1  downstream accepts the beat.
- address1  output  LOG2N  first sample address.
- address2  output  LOG2N  second sample address.
- twiddle_address  output  LOG2N-1  twiddle ROM index (ROM holds N/2 entries).
- stage_out  output  LOG2N  stage of the current beat.
- last_in_stage  output  1  current beat is the final pair of its stage.
- last  output  1  current beat is the final beat of the transform.

Behaviour:
- Reset (async, any time including mid-run): state IDLE; busy, done, out_valid, last, last_in_stage = 0; addresses, twiddle_address, stage_out = 0; counters cleared. The in-flight transform is discarded.
- Size: L = cfg_log2n latched at an accepted start; cfg_log2n = 0 or > LOG2N is treated as LOG2N. L = 1 is legal (one stage, one pair).
- States: IDLE, RUN, GAP.
- IDLE + start: load beat (stage 0, pair 0) into the output registers, out_valid = 1 and busy = 1 from the next cycle, then go to RUN. Start-to-first-valid latency is 1 cycle.
- Start while busy is ignored.
- Beat acceptance: out_valid && out_ready at a rising edge. While out_valid && !out_ready, all outputs hold stable.
- RUN, accepted beat that is not the last of its stage: load pair+1 at the same edge. Back-to-back throughput is 1 beat/cycle.
- RUN, accepted last_in_stage beat with stage < L-1:
  - STAGE_GAP = 0: load (stage+1, pair 0) at that edge.
  - STAGE_GAP > 0: out_valid = 0 and go to GAP. The gap counter runs STAGE_GAP cycles, then (stage+1, 0) is loaded, out_valid rises, and the block returns to RUN. out_valid is low for exactly STAGE_GAP cycles.
- RUN, accepted last beat: out_valid = 0, busy = 0 and done = 1 for one cycle, then go to IDLE. A start in the done cycle is accepted.
- Arithmetic, computed on an L-bit field; address bits [LOG2N-1:L] are 0:
  - address1 = rotate-left of (2*pair) by stage, within L bits.
  - address2 = rotate-left of (2*pair+1) by stage, within L bits.
  - twiddle_address = (pair & ((1<<stage)-1)) << (LOG2N-L). This scales the index into the N-point ROM; the stage-0 twiddle is always 0.
- Ranges: pair is 0..2^(L-1)-1; stage is 0..L-1.
  - last_in_stage = (pair == 2^(L-1)-1).
  - last = last_in_stage && (stage == L-1).
- Beats per transform = L*2^(L-1). No gap follows the final stage.

Test Plan:
- N=16, G=0, cfg=4, out_ready=1 -> first valid 1 cycle after start; 32 consecutive beats; done 1 cycle after beat 32 is accepted; stage1/pair5 beat gives address1=5, address2=7, twiddle=1.
- N=16, cfg=3, out_ready=1 -> 12 beats; stage2/pair3 beat gives address1=3, address2=7, twiddle=6; address bit 3 always 0.
- N=16, G=2, cfg=4 -> out_valid low exactly 2 cycles after each of the first 3 stages; 38 cycles from first valid to last beat; no gap after stage 3.
- Random out_ready (~50%) -> outputs stable while stalled; beat sequence identical to the ready=1 run; no beat dropped or duplicated.
- cfg=0, then cfg=7 with N=16 -> both run as L=4; cfg=1 -> single beat: address1=0, address2=1, twiddle=0, last=1.
- rst asserted mid-stage-2 -> all outputs 0 immediately (async); a new start runs a clean transform from stage 0/pair 0. A start pulsed while busy has no effect.

Source files
------------

// File: rtl/agu_seq.sv
// agu_seq: self-sequencing address generator for an in-place constant-geometry
// radix-2 FFT. Walks every (stage, pair) butterfly for a run-time size L and
// streams rotated sample addresses plus a size-scaled twiddle index over a
// valid/ready handshake, with optional idle gaps between stages.
module agu_seq #(
   parameter int unsigned N          = 1024,
   parameter int unsigned STAGE_GAP  = 0,
   localparam int unsigned LOG2N     = $clog2(N),
   localparam int unsigned CW        = $clog2(LOG2N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CW-1:0]    cfg_log2n,
   output logic             busy,
   output logic             done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOG2N-1:0] address1,
   output logic [LOG2N-1:0] address2,
   output logic [LOG2N-2:0] twiddle_address,
   output logic [LOG2N-1:0] stage_out,
   output logic             last_in_stage,
   output logic             last
);

   localparam logic [LOG2N-1:0] STAGE_ONE = LOG2N'(1);
   localparam logic [LOG2N-2:0] PAIR_ONE  = (LOG2N-1)'(1);
   localparam logic [CW-1:0]    L_MAX     = CW'(LOG2N);
   // Wraps harmlessly when STAGE_GAP is 0: the gap state is never entered then.
   localparam logic [7:0]       GAP_LAST  = 8'(STAGE_GAP - 1);

   typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

   state_e           state_q, state_d;
   logic [LOG2N-1:0] stage_q, stage_d;
   logic [LOG2N-2:0] pair_q, pair_d;
   logic [CW-1:0]    l_q, l_d;
   logic [7:0]       gap_q, gap_d;
   logic             valid_d, done_d, load;
   logic [CW-1:0]    l_eff;

   logic [LOG2N-1:0] x1, x2, a1_c, a2_c;
   logic [LOG2N-2:0] tw_raw, tw_c, pmax;
   logic             lis_c, last_c;
   int               ln, sn;

   assign busy  = (state_q != StIdle);
   // Out-of-range or zero size requests fall back to the full transform.
   assign l_eff = ((cfg_log2n == '0) || (int'(cfg_log2n) > int'(LOG2N))) ? L_MAX : cfg_log2n;

   // Next-state: sequence stages/pairs, honour back-pressure, insert stage gaps.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      pair_d  = pair_q;
      l_d     = l_q;
      gap_d   = gap_q;
      valid_d = out_valid;
      done_d  = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               l_d     = l_eff;
               stage_d = '0;
               pair_d  = '0;
               load    = 1'b1;
               valid_d = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (out_valid && out_ready) begin
               if (last) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else if (last_in_stage) begin
                  stage_d = stage_q + STAGE_ONE;
                  pair_d  = '0;
                  if (STAGE_GAP == 0) begin
                     load = 1'b1;
                  end else begin
                     valid_d = 1'b0;
                     gap_d   = '0;
                     state_d = StGap;
                  end
               end else begin
                  pair_d = pair_q + PAIR_ONE;
                  load   = 1'b1;
               end
            end
         end
         StGap: begin
            if (gap_q == GAP_LAST) begin
               load    = 1'b1;
               valid_d = 1'b1;
               state_d = StRun;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Beat arithmetic for the (stage_d, pair_d) about to be loaded, on an L-bit field.
   always_comb begin
      ln     = int'(l_d);
      sn     = int'(stage_d);
      x1     = {pair_d, 1'b0};
      x2     = {pair_d, 1'b1};
      a1_c   = '0;
      a2_c   = '0;
      tw_raw = '0;
      pmax   = '0;
      // Rotate-left by sn within ln bits: source bit i lands at (i + sn) mod ln.
      for (int k = 0; k < LOG2N; k++) begin
         for (int i = 0; i < LOG2N; i++) begin
            if ((i < ln) && (k < ln) && ((i + sn == k) || (i + sn == k + ln))) begin
               a1_c[k] = x1[i];
               a2_c[k] = x2[i];
            end
         end
      end
      for (int i = 0; i < LOG2N - 1; i++) begin
         tw_raw[i] = pair_d[i] & (i < sn);
         pmax[i]   = (i < ln - 1);
      end
      // Scale the index into the N-point twiddle ROM.
      tw_c   = tw_raw << (int'(LOG2N) - ln);
      lis_c  = (pair_d == pmax);
      last_c = lis_c && (sn == ln - 1);
   end

   // State, counters and registered beat outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= StIdle;
         stage_q         <= '0;
         pair_q          <= '0;
         l_q             <= '0;
         gap_q           <= '0;
         out_valid       <= 1'b0;
         done            <= 1'b0;
         address1        <= '0;
         address2        <= '0;
         twiddle_address <= '0;
         stage_out       <= '0;
         last_in_stage   <= 1'b0;
         last            <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         pair_q    <= pair_d;
         l_q       <= l_d;
         gap_q     <= gap_d;
         out_valid <= valid_d;
         done      <= done_d;
         if (load) begin
            address1        <= a1_c;
            address2        <= a2_c;
            twiddle_address <= tw_c;
            stage_out       <= stage_d;
            last_in_stage   <= lis_c;
            last            <= last_c;
         end
      end
   end

endmodule

// File: tb/tb_agu_seq.sv
// Bench for agu_seq at N=16: one instance without stage gaps, one with a
// two-cycle gap. Expected beats come from an independent model and are
// queued at start, then popped as the DUT hands beats over.
module tb_agu_seq;

   typedef struct packed {
      logic [3:0] a1;
      logic [3:0] a2;
      logic [2:0] tw;
      logic [3:0] st;
      logic       lis;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sel = 1'b0;
   logic [2:0] cfg = 3'd4;
   logic       out_ready = 1'b1;

   logic       start0, start2;
   logic       busy0, done0, valid0, lis0, last0;
   logic       busy2, done2, valid2, lis2, last2;
   logic [3:0] a10, a20, st0, a12, a22, st2;
   logic [2:0] tw0, tw2;

   logic       o_busy, o_done, o_valid, o_lis, o_last;
   logic [3:0] o_a1, o_a2, o_st;
   logic [2:0] o_tw;

   int checks = 0;
   int errors = 0;

   beat_t exp_q[$];
   beat_t obs[$];
   beat_t ref_obs[$];
   int    gaps[$];

   always #5 clk = ~clk;

   assign start0 = start & ~sel;
   assign start2 = start & sel;

   agu_seq #(.N(16), .STAGE_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .cfg_log2n(cfg),
      .busy(busy0), .done(done0), .out_valid(valid0), .out_ready(out_ready),
      .address1(a10), .address2(a20), .twiddle_address(tw0), .stage_out(st0),
      .last_in_stage(lis0), .last(last0)
   );

   agu_seq #(.N(16), .STAGE_GAP(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .cfg_log2n(cfg),
      .busy(busy2), .done(done2), .out_valid(valid2), .out_ready(out_ready),
      .address1(a12), .address2(a22), .twiddle_address(tw2), .stage_out(st2),
      .last_in_stage(lis2), .last(last2)
   );

   assign o_busy  = sel ? busy2  : busy0;
   assign o_done  = sel ? done2  : done0;
   assign o_valid = sel ? valid2 : valid0;
   assign o_lis   = sel ? lis2   : lis0;
   assign o_last  = sel ? last2  : last0;
   assign o_a1    = sel ? a12    : a10;
   assign o_a2    = sel ? a22    : a20;
   assign o_st    = sel ? st2    : st0;
   assign o_tw    = sel ? tw2    : tw0;

   function automatic beat_t cur_beat();
      beat_t b;
      b = '{a1: o_a1, a2: o_a2, tw: o_tw, st: o_st, lis: o_lis, last: o_last};
      return b;
   endfunction

   // Reference: rotate one bit at a time; twiddle = (pair mod 2^s) * 2^(4-l).
   function automatic beat_t model(input int l, input int s, input int p);
      beat_t b;
      int    mask, x1, x2, t;
      mask = (1 << l) - 1;
      x1 = 2 * p;
      x2 = 2 * p + 1;
      for (int k = 0; k < s; k++) begin
         x1 = ((x1 << 1) | (x1 >> (l - 1))) & mask;
         x2 = ((x2 << 1) | (x2 >> (l - 1))) & mask;
      end
      t = (p % (1 << s)) * (1 << (4 - l));
      b.a1   = x1[3:0];
      b.a2   = x2[3:0];
      b.tw   = t[2:0];
      b.st   = 4'(s);
      b.lis  = (p == (1 << (l - 1)) - 1);
      b.last = b.lis && (s == l - 1);
      return b;
   endfunction

   task automatic push_expected(input int l);
      for (int s = 0; s < l; s++)
         for (int p = 0; p < (1 << (l - 1)); p++)
            exp_q.push_back(model(l, s, p));
   endtask

   // Run one transform on the selected instance, scoreboarding every beat.
   task automatic run_xfer(input logic [2:0] c, input int exp_l, input logic g,
                           input bit rnd, input bit poke, output int span);
      bit    finished, stalled, seen_first, poked, early_done, rdy;
      int    first_cyc, gap_run, acc;
      beat_t cur, snap, e;
      finished = 0; stalled = 0; seen_first = 0; poked = 0; early_done = 0;
      first_cyc = 0; gap_run = 0; acc = 0; span = 0;
      snap = '0;
      obs.delete();
      gaps.delete();
      exp_q.delete();
      sel = g;
      push_expected(exp_l);
      @(negedge clk);
      cfg = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (o_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_valid: got %b want 1", o_valid);
      end
      for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (poke && acc == 5 && !poked) begin
            start = 1'b1;
            cfg = 3'd1;
            poked = 1;
         end else begin
            start = 1'b0;
         end
         rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         out_ready = rdy;
         cur = cur_beat();
         if (stalled) begin
            checks++;
            if (cur !== snap || o_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_stable: got %h valid %b want %h", cur, o_valid, snap);
            end
         end
         if (o_done) early_done = 1;
         if (o_valid) begin
            if (!seen_first) begin
               seen_first = 1;
               first_cyc = cyc;
            end
            if (gap_run > 0) gaps.push_back(gap_run);
            gap_run = 0;
         end else if (seen_first) begin
            gap_run++;
         end
         if (o_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: got %h want none", cur);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  errors++;
                  $display("FAIL beat %0d: got %h want %h", acc, cur, e);
               end
            end
            obs.push_back(cur);
            acc++;
            if (cur.last) begin
               finished = 1;
               span = cyc - first_cyc + 1;
            end
         end
         stalled = o_valid && !rdy;
         snap = cur;
      end
      start = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL timeout: got %0d beats want %0d", acc, exp_l << (exp_l - 1) >> 0);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_beats: got %0d left want 0", exp_q.size());
      end
      checks++;
      if (early_done) begin
         errors++;
         $display("FAIL early_done: got 1 want 0");
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: got done %b busy %b valid %b want 1 0 0",
                  o_done, o_busy, o_valid);
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0) begin
         errors++;
         $display("FAIL done_one_cycle: got %b want 0", o_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_busy, o_done, o_valid, o_lis, o_last, o_a1, o_a2, o_tw, o_st} !== '0) begin
         errors++;
         $display("FAIL reset_state: got %b want 0",
                  {o_busy, o_done, o_valid, o_lis, o_last, o_a1, o_a2, o_tw, o_st});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_g0();
      int span;
      run_xfer(3'd4, 4, 1'b0, 0, 0, span);
      checks++;
      if (span != 32 || obs.size() != 32) begin
         errors++;
         $display("FAIL full_span: got %0d cycles %0d beats want 32 32", span, obs.size());
      end
      checks++;
      if (obs.size() > 13 && (obs[13].a1 !== 4'd5 || obs[13].a2 !== 4'd7 || obs[13].tw !== 3'd1)) begin
         errors++;
         $display("FAIL s1p5: got %0d %0d %0d want 5 7 1", obs[13].a1, obs[13].a2, obs[13].tw);
      end
      ref_obs = obs;
   endtask

   task automatic test_cfg3();
      int span;
      bit bad;
      run_xfer(3'd3, 3, 1'b0, 0, 0, span);
      checks++;
      if (obs.size() != 12 || obs[11].a1 !== 4'd3 || obs[11].a2 !== 4'd7 || obs[11].tw !== 3'd6) begin
         errors++;
         $display("FAIL cfg3_s2p3: got n=%0d beat %h want n=12 a1 3 a2 7 tw 6",
                  obs.size(), obs[obs.size()-1]);
      end
      bad = 0;
      foreach (obs[i]) if (obs[i].a1[3] || obs[i].a2[3]) bad = 1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL cfg3_bit3: got 1 want 0");
      end
   endtask

   task automatic test_gap();
      int span;
      run_xfer(3'd4, 4, 1'b1, 0, 0, span);
      checks++;
      if (span != 38) begin
         errors++;
         $display("FAIL gap_span: got %0d want 38", span);
      end
      checks++;
      if (gaps.size() != 3 || gaps[0] != 2 || gaps[1] != 2 || gaps[2] != 2) begin
         errors++;
         $display("FAIL gap_runs: got %0d runs want 3 runs of 2", gaps.size());
      end
      sel = 1'b0;
   endtask

   task automatic test_random_ready();
      int span;
      bit same;
      run_xfer(3'd4, 4, 1'b0, 1, 0, span);
      same = (obs.size() == ref_obs.size());
      foreach (obs[i]) if (i < ref_obs.size() && obs[i] !== ref_obs[i]) same = 0;
      checks++;
      if (!same) begin
         errors++;
         $display("FAIL random_seq: got %0d beats want identical %0d", obs.size(), ref_obs.size());
      end
      run_xfer(3'd3, 3, 1'b1, 1, 0, span);
   endtask

   task automatic test_cfg_clamp();
      int span;
      run_xfer(3'd0, 4, 1'b0, 0, 0, span);
      checks++;
      if (span != 32) begin
         errors++;
         $display("FAIL cfg0_span: got %0d want 32", span);
      end
      run_xfer(3'd7, 4, 1'b0, 0, 0, span);
      checks++;
      if (span != 32) begin
         errors++;
         $display("FAIL cfg7_span: got %0d want 32", span);
      end
      run_xfer(3'd1, 1, 1'b0, 0, 0, span);
      checks++;
      if (obs.size() != 1 || obs[0].a1 !== 4'd0 || obs[0].a2 !== 4'd1 || obs[0].tw !== 3'd0
          || obs[0].last !== 1'b1) begin
         errors++;
         $display("FAIL cfg1_single: got n=%0d beat %h want one beat a1 0 a2 1 tw 0 last 1",
                  obs.size(), obs[0]);
      end
   endtask

   task automatic test_busy_start();
      int span;
      // A start with cfg=1 mid-run must leave the L=4 sequence untouched.
      run_xfer(3'd4, 4, 1'b0, 0, 1, span);
      checks++;
      if (span != 32) begin
         errors++;
         $display("FAIL busy_start_span: got %0d want 32", span);
      end
   endtask

   task automatic test_async_reset();
      int  span;
      bit  hit;
      sel = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      cfg = 3'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (o_st == 4'd2) hit = 1;
         else @(negedge clk);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL reach_stage2: got stage %0d want 2", o_st);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({o_busy, o_done, o_valid, o_lis, o_last, o_a1, o_a2, o_tw, o_st} !== '0) begin
         errors++;
         $display("FAIL async_reset: got %b want 0",
                  {o_busy, o_done, o_valid, o_lis, o_last, o_a1, o_a2, o_tw, o_st});
      end
      @(negedge clk);
      rst = 1'b0;
      run_xfer(3'd4, 4, 1'b0, 0, 0, span);
   endtask

   task automatic test_start_in_done();
      sel = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      cfg = 3'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (o_valid !== 1'b1 || o_last !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: got valid %b last %b want 1 1", o_valid, o_last);
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done1: got %b want 1", o_done);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_a2 !== 4'd1) begin
         errors++;
         $display("FAIL b2b_restart: got valid %b busy %b a2 %0d want 1 1 1",
                  o_valid, o_busy, o_a2);
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done2: got %b want 1", o_done);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_g0();
      test_cfg3();
      test_gap();
      test_random_ready();
      test_cfg_clamp();
      test_busy_start();
      test_async_reset();
      test_start_in_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
